spi_cfg_slave: RTL and testbench
================================

// Module: spi_cfg_slave
// PURPOSE
// - SPI slave (mode 0, CPOL=0/CPHA=0, MSB first) feeding the demoscene configuration register file.
// - Sits between the SCLK/SSEL/MOSI/MISO pads and the effect/audio generators.
// - Oversamples the SPI pins on clk, decodes 16-bit frames and writes or reads an internal bank of 8-bit registers.
// - Exposes the register bank as a flat bus for downstream consumers.
// PARAMETERS
// - NUM_REGS  16  number of 8-bit config registers (1..128)
// - RST_VAL   0   reset value of every register (8-bit)
// PORTS
// - clk        in   1             system clock (pixel clock domain)
// - rst        in   1             asynchronous reset, active-high
// - sclk       in   1             SPI clock, asynchronous to clk
// - ssel       in   1             SPI select, active-low, asynchronous
// - mosi       in   1             SPI data in, asynchronous
// - miso       out  1             SPI data out
// - cfg_flat   out  NUM_REGS*8    register i at cfg_flat[i*8 +: 8]
// - wr_strobe  out  1             one-cycle pulse when a register is written
// - wr_addr    out  7             address of the last accepted write
// - frame_err  out  1             one-cycle pulse when a frame is aborted before 16 bits
// BEHAVIOUR
// - Interface: one clock, clk; reset rst is asynchronous and active-high.
// - Reset values:
//   - all registers = RST_VAL; miso = 0; wr_strobe = 0; wr_addr = 0; frame_err = 0.
//   - FSM = IDLE; synchronizer flops reset to idle pin levels (sclk=0, ssel=1, mosi=0).
// - Synchronization:
//   - sclk, ssel and mosi each pass through a 2-flop synchronizer.
//   - sclk_rise and sclk_fall are single-cycle pulses taken from the 2nd and 3rd flops.
//   - Requirement: SCLK frequency <= clk/4.
// - Frame format (16 bits): bit15 = W (1=write, 0=read); bits14:8 = addr[6:0]; bits7:0 = data.
// - FSM states and transitions:
//   - IDLE: wait for synchronized ssel=0; on entry clear bit_cnt; go to CMD.
//   - CMD: shift mosi into rx_shift on each sclk_rise.
//     - After the 8th rise, latch W/addr and go to DATA_WR (W=1) or DATA_RD (W=0).
//   - DATA_WR: shift on rise. On the 16th rise:
//     - if addr < NUM_REGS: write the register on that clk edge (visible on cfg_flat the next cycle);
//       wr_strobe=1 for one cycle; wr_addr=addr.
//     - if addr >= NUM_REGS: write ignored, no strobe.
//     - Then go to DONE.
//   - DATA_RD:
//     - on the falling edge following bit 8, load tx_shift = reg[addr] (0x00 if addr >= NUM_REGS);
//     - shift tx_shift left on falls 9..15;
//     - on the 16th rise go to DONE.
//   - DONE: ignore further SCLK activity; return to IDLE when ssel=1.
// - miso = tx_shift[7] in DATA_RD after the load, else 0.
// - ssel deassert (synchronized) in CMD/DATA_WR/DATA_RD: frame_err=1 for one cycle, no write, go to IDLE.
// - ssel deassert in IDLE/DONE: return to IDLE silently.
// - A register write and a read of the same address in different frames: the read returns the new value.
//   No simultaneous frames are possible.
// - rst asserted mid-frame: the partial frame is discarded and registers return to RST_VAL.
// - sclk edges while ssel=1 are ignored.
// STRUCTURE
// - Shared package: FRAME_BITS=16, CMD_BITS=8, W_BIT=15, ADDR_MSB=14, ADDR_LSB=8, FSM state enum.
// - Sub-module spi_pin_sync: 2-flop synchronizer plus 3rd flop for edge detect.
//   - Instantiated once for sclk (rise/fall outputs).
//   - ssel and mosi use level-only instances.
// - Register bank and FSM live in spi_cfg_slave; cfg_flat is driven directly from the bank flops.
// TESTING
// - Reset: assert rst mid-run -> cfg_flat all RST_VAL, miso=0, FSM in IDLE within the same cycle (async).
// - Write: frame 0x83A5 (W=1, addr 3, data 0xA5) -> reg3=0xA5; wr_strobe one pulse with wr_addr=3;
//   all other regs unchanged.
// - Read: after the write above, frame 0x0300 -> miso shifts 1010_0101 on rises 9..16; no wr_strobe.
// - Out of range: write 0xFF11 with NUM_REGS=16 -> no strobe, no register change;
//   read 0x7F00 -> miso returns 0x00.
// - Abort: raise ssel after 11 bits of 0x8255 -> frame_err one pulse, reg2 unchanged;
//   the next full frame 0x8255 -> reg2=0x55.
// - Back-to-back frames with 2 SCLK periods of ssel high, at the SCLK=clk/4 limit:
//   writes 0x8001 then 0x8102 -> reg0=0x01, reg1=0x02, two strobes, no frame_err.

Source files
------------

// File: rtl/spi_cfg_slave_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI configuration slave.
package spi_cfg_slave_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CMD_BITS   = 8;
   localparam int W_BIT      = 15;
   localparam int ADDR_MSB   = 14;
   localparam int ADDR_LSB   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA_WR,
      ST_DATA_RD,
      ST_DONE
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one SPI pad, with an optional third flop for edge pulses.
module spi_pin_sync #(
   parameter logic RST_LVL  = 1'b0,
   parameter bit   EDGE_DET = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic s1, s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= RST_LVL;
         s2 <= RST_LVL;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   assign lvl = s2;

   generate
      if (EDGE_DET) begin : g_edge
         logic s3;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) s3 <= RST_LVL;
            else     s3 <= s2;
         end
         assign rise = s2 & ~s3;
         assign fall = ~s2 & s3;
      end else begin : g_level
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 slave decoding 16-bit W/addr/data frames into a bank of 8-bit config registers.
//
// state      | meaning
// ST_IDLE    | waiting for ssel low, bit counter held clear
// ST_CMD     | shifting in W + 7-bit address (rises 1..8)
// ST_DATA_WR | shifting in write data, commit on rise 16
// ST_DATA_RD | shifting out reg[addr] on miso, load on fall 8
// ST_DONE    | frame complete, ignore sclk until ssel high
module spi_cfg_slave
   import spi_cfg_slave_pkg::*;
#(
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  ssel,
   input  logic                  mosi,
   output logic                  miso,
   output logic [NUM_REGS*8-1:0] cfg_flat,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic                  frame_err
);

   localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
   localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
   localparam logic [4:0] LOAD_CNT   = 5'(CMD_BITS);

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic ssel_s, ssel_unused_rise, ssel_unused_fall;
   logic mosi_s, mosi_unused_rise, mosi_unused_fall;

   spi_pin_sync #(.RST_LVL(1'b0), .EDGE_DET(1'b1)) u_sync_sclk (
      .clk(clk), .rst(rst), .pin(sclk), .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
   spi_pin_sync #(.RST_LVL(1'b1), .EDGE_DET(1'b0)) u_sync_ssel (
      .clk(clk), .rst(rst), .pin(ssel), .lvl(ssel_s), .rise(ssel_unused_rise), .fall(ssel_unused_fall));
   spi_pin_sync #(.RST_LVL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .pin(mosi), .lvl(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall));

   state_t     state, state_nxt;
   logic [4:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] rx_byte;
   logic [6:0] cmd_addr;
   logic [7:0] tx_shift, rd_data;
   logic       tx_valid;
   logic [7:0] regs [NUM_REGS];

   logic shift_rx, latch_cmd, do_write, load_tx, shift_tx, abort, clr_cnt, addr_ok;

   // The byte being completed on this rise: seven held bits plus the live mosi sample.
   assign rx_byte = {rx_shift, mosi_s};
   assign addr_ok = int'(cmd_addr) < NUM_REGS;

   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < NUM_REGS; i++)
         if (cmd_addr == 7'(i)) rd_data = regs[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_rx  = 1'b0;
      latch_cmd = 1'b0;
      do_write  = 1'b0;
      load_tx   = 1'b0;
      shift_tx  = 1'b0;
      abort     = 1'b0;
      clr_cnt   = 1'b0;
      case (state)
         ST_IDLE: begin
            clr_cnt = 1'b1;
            if (!ssel_s) state_nxt = ST_CMD;
         end
         ST_CMD: begin
            if (ssel_s) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == CMD_LAST) begin
                  latch_cmd = 1'b1;
                  state_nxt = rx_byte[W_BIT-CMD_BITS] ? ST_DATA_WR : ST_DATA_RD;
               end
            end
         end
         ST_DATA_WR: begin
            if (ssel_s) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == FRAME_LAST) begin
                  do_write  = addr_ok;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DATA_RD: begin
            if (ssel_s) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == FRAME_LAST) state_nxt = ST_DONE;
            end else if (sclk_fall) begin
               // bit_cnt counts completed rises, so fall 8 sees 8 here
               if (bit_cnt == LOAD_CNT)    load_tx  = 1'b1;
               else if (bit_cnt > LOAD_CNT) shift_tx = 1'b1;
            end
         end
         ST_DONE: begin
            if (ssel_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_shift  <= '0;
         cmd_addr  <= '0;
         tx_shift  <= '0;
         tx_valid  <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      end else begin
         wr_strobe <= do_write;
         frame_err <= abort;
         if (clr_cnt)       bit_cnt <= '0;
         else if (shift_rx) bit_cnt <= bit_cnt + 5'd1;
         if (shift_rx)  rx_shift <= rx_byte[6:0];
         if (latch_cmd) cmd_addr <= rx_byte[ADDR_MSB-CMD_BITS:ADDR_LSB-CMD_BITS];
         if (clr_cnt)      tx_valid <= 1'b0;
         else if (load_tx) tx_valid <= 1'b1;
         if (load_tx)       tx_shift <= rd_data;
         else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};
         if (do_write) begin
            wr_addr <= cmd_addr;
            for (int i = 0; i < NUM_REGS; i++)
               if (cmd_addr == 7'(i)) regs[i] <= rx_byte;
         end
      end
   end

   assign miso = (state == ST_DATA_RD) && tx_valid && tx_shift[7];

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign cfg_flat[g*8 +: 8] = regs[g];
      end
   endgenerate

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Randomized frame-level bench for spi_cfg_slave against an array model of the register bank.
module tb_spi_cfg_slave;

   localparam int         NUM_REGS = 16;
   localparam logic [7:0] RST_VAL  = 8'h00;

   logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ssel = 1'b1, mosi = 1'b0;
   logic miso, wr_strobe, frame_err;
   logic [6:0] wr_addr;
   logic [NUM_REGS*8-1:0] cfg_flat;

   int total = 0, bad = 0;
   int strobe_cnt = 0, err_cnt = 0;
   logic [6:0] strobe_addr = '0;

   logic [7:0] model_regs [128];
   int exp_strobes = 0, exp_errs = 0;
   logic [6:0] exp_wr_addr = '0;

   always #5 clk = ~clk;

   spi_cfg_slave #(.NUM_REGS(NUM_REGS), .RST_VAL(RST_VAL)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ssel(ssel), .mosi(mosi), .miso(miso),
      .cfg_flat(cfg_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err));

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_strobe) begin
            strobe_cnt++;
            strobe_addr = wr_addr;
         end
         if (frame_err) err_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] f = '0;
      for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = model_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) model_regs[i] = RST_VAL;
      exp_wr_addr = '0;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 master: mosi changes with sclk low, miso sampled just before each rise 9..16.
   task automatic spi_xfer(input logic [15:0] word, input int nbits, input int half,
                           input bit end_frame, output logic [7:0] rd);
      rd   = '0;
      ssel = 1'b0;
      wait_neg(half);
      for (int k = 0; k < nbits; k++) begin
         mosi = word[15-k];
         wait_neg(half);
         if (k >= 8) rd[15-k] = miso;
         sclk = 1'b1;
         wait_neg(half);
         sclk = 1'b0;
      end
      if (end_frame) begin
         wait_neg(half);
         ssel = 1'b1;
         mosi = 1'b0;
         wait_neg(4*half);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cfg"}, cfg_flat, model_flat());
      chk({tag, "_strobes"}, strobe_cnt, exp_strobes);
      chk({tag, "_wr_addr"}, wr_addr, exp_wr_addr);
      chk({tag, "_errs"}, err_cnt, exp_errs);
   endtask

   task automatic do_frame(input string tag, input logic [15:0] word, input int half);
      logic [7:0] rd;
      logic [6:0] a;
      a = word[14:8];
      spi_xfer(word, 16, half, 1'b1, rd);
      if (word[15]) begin
         if (a < NUM_REGS) begin
            model_regs[a] = word[7:0];
            exp_strobes++;
            exp_wr_addr = a;
            chk({tag, "_strobe_addr"}, strobe_addr, a);
         end
      end else begin
         chk({tag, "_rd"}, rd, (a < NUM_REGS) ? model_regs[a] : 8'h00);
      end
      check_state(tag);
   endtask

   initial begin
      logic [7:0]  rd;
      logic        w;
      logic [6:0]  a;
      logic [7:0]  d;
      int          half;

      model_reset();
      wait_neg(4);
      chk("rst_cfg", cfg_flat, model_flat());
      chk("rst_miso", miso, 1'b0);
      chk("rst_strobe", wr_strobe, 1'b0);
      chk("rst_wr_addr", wr_addr, 7'd0);
      chk("rst_frame_err", frame_err, 1'b0);
      rst = 1'b0;
      wait_neg(4);

      do_frame("wr_83a5", 16'h83A5, 4);
      do_frame("rd_0300", 16'h0300, 4);
      do_frame("wr_ff11", 16'hFF11, 4);
      do_frame("rd_7f00", 16'h7F00, 4);

      spi_xfer(16'h8255, 11, 4, 1'b1, rd);
      exp_errs++;
      check_state("abort_8255");
      do_frame("wr_8255", 16'h8255, 4);

      do_frame("b2b_8001", 16'h8001, 2);
      do_frame("b2b_8102", 16'h8102, 2);

      for (int n = 0; n < 24; n++) begin
         w    = 1'($urandom_range(0, 1));
         a    = 7'($urandom_range(0, 19));
         d    = 8'($urandom);
         half = w ? $urandom_range(2, 6) : $urandom_range(4, 6);
         do_frame(w ? "rnd_wr" : "rnd_rd", {w, a, d}, half);
      end

      do_frame("pre_rst_wr", 16'h81C3, 4);
      spi_xfer(16'h0100, 9, 4, 1'b0, rd);
      wait_neg(4);
      chk("pre_rst_miso", miso, 1'b1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_cfg", cfg_flat, model_flat());
      chk("mid_rst_miso", miso, 1'b0);
      chk("mid_rst_wr_addr", wr_addr, 7'd0);
      ssel = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      wait_neg(4);
      rst = 1'b0;
      wait_neg(4);
      do_frame("post_rst_wr", 16'h8533, 4);
      do_frame("post_rst_rd", 16'h0500, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test done");
      $fatal(1);
   end

endmodule
